// File: rtl/mem_access.sv
// mem_access: MEM-stage data-memory access controller for a 16-bit LC-3b pipeline.
//
// Accepts one memory instruction from the EX/MEM register, runs one data-memory
// handshake (or two for the indirect ops LDI/STI), and then reports completion.
// The upstream pipeline is stalled for the whole time an access is in flight.
//
// Ports
//   clk, reset_n        clock; asynchronous active-low reset
//   valid_in, op        EX/MEM holds a valid instruction; 3-bit memory opcode
//   addr_in, store_data effective address; store source data
//   flush               kill the current or pending access result
//   dmem_*              data-memory request (address, wdata, byte_enable,
//                       read/write strobes) and response (resp, rdata)
//   stall               upstream must hold while high
//   done, mem_data      one-cycle completion pulse; load result (held)
//
// state    | meaning
// ---------+-------------------------------------------------------------
// IDLE     | no access in flight; accept a memory op when not flushed
// ACCESS   | first request: data access, or pointer fetch for LDI/STI
// INDIRECT | second request of LDI/STI at the fetched pointer
// REPORT   | single cycle with done high, then back to IDLE

module mem_access (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        valid_in,
  input  logic [2:0]  op,
  input  logic [15:0] addr_in,
  input  logic [15:0] store_data,
  input  logic        flush,
  output logic [15:0] dmem_address,
  output logic [15:0] dmem_wdata,
  output logic [1:0]  dmem_byte_enable,
  output logic        dmem_read,
  output logic        dmem_write,
  input  logic        dmem_resp,
  input  logic [15:0] dmem_rdata,
  output logic        stall,
  output logic        done,
  output logic [15:0] mem_data
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ACCESS   = 2'd1,
    INDIRECT = 2'd2,
    REPORT   = 2'd3
  } state_t;

  localparam logic [2:0] OP_NONE = 3'b000;
  localparam logic [2:0] OP_LDR  = 3'b001;
  localparam logic [2:0] OP_LDB  = 3'b010;
  localparam logic [2:0] OP_STR  = 3'b011;
  localparam logic [2:0] OP_STB  = 3'b100;
  localparam logic [2:0] OP_LDI  = 3'b101;
  localparam logic [2:0] OP_STI  = 3'b110;
  localparam logic [2:0] OP_RSVD = 3'b111;

  state_t      state_q, state_d;
  logic [2:0]  op_q;
  logic [15:0] addr_q;
  logic [15:0] data_q;
  logic        kill_q;

  logic        mem_op;
  logic        accept;
  logic        kill;
  logic        ptr_en;
  logic        load_en;
  logic [15:0] load_val;

  assign mem_op = (op != OP_NONE) && (op != OP_RSVD);
  assign accept = (state_q == IDLE) && valid_in && mem_op && !flush;
  // A flush arriving in the response cycle itself still kills the result.
  assign kill   = kill_q | flush;
  assign stall  = (state_q != IDLE) || accept;

  always_comb begin
    state_d          = state_q;
    dmem_address     = 16'h0000;
    dmem_wdata       = 16'h0000;
    dmem_byte_enable = 2'b00;
    dmem_read        = 1'b0;
    dmem_write       = 1'b0;
    done             = 1'b0;
    ptr_en           = 1'b0;
    load_en          = 1'b0;
    load_val         = dmem_rdata;

    case (state_q)
      IDLE: begin
        if (accept) state_d = ACCESS;
      end

      ACCESS: begin
        dmem_address = {addr_q[15:1], 1'b0};
        case (op_q)
          OP_STR: begin
            dmem_write       = 1'b1;
            dmem_wdata       = data_q;
            dmem_byte_enable = 2'b11;
          end
          OP_STB: begin
            dmem_write       = 1'b1;
            dmem_wdata       = {data_q[7:0], data_q[7:0]};
            dmem_byte_enable = addr_q[0] ? 2'b10 : 2'b01;
          end
          default: begin
            // LDR, LDB, and the pointer fetch of LDI/STI are all word reads.
            dmem_read        = 1'b1;
            dmem_byte_enable = 2'b11;
          end
        endcase

        if (dmem_resp) begin
          if (kill) begin
            state_d = IDLE;
          end else if ((op_q == OP_LDI) || (op_q == OP_STI)) begin
            state_d = INDIRECT;
            ptr_en  = 1'b1;
          end else begin
            state_d = REPORT;
            load_en = (op_q == OP_LDR) || (op_q == OP_LDB);
            if (op_q == OP_LDB)
              load_val = addr_q[0] ? {8'h00, dmem_rdata[15:8]}
                                   : {8'h00, dmem_rdata[7:0]};
          end
        end
      end

      INDIRECT: begin
        dmem_address     = {addr_q[15:1], 1'b0};
        dmem_byte_enable = 2'b11;
        if (op_q == OP_STI) begin
          dmem_write = 1'b1;
          dmem_wdata = data_q;
        end else begin
          dmem_read = 1'b1;
        end

        if (dmem_resp) begin
          if (kill) begin
            state_d = IDLE;
          end else begin
            state_d = REPORT;
            load_en = (op_q == OP_LDI);
          end
        end
      end

      REPORT: begin
        done    = 1'b1;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= IDLE;
      op_q     <= OP_NONE;
      addr_q   <= 16'h0000;
      data_q   <= 16'h0000;
      kill_q   <= 1'b0;
      mem_data <= 16'h0000;
    end else begin
      state_q <= state_d;

      if (accept) begin
        op_q   <= op;
        addr_q <= addr_in;
        data_q <= store_data;
      end else if (ptr_en) begin
        // The fetched pointer replaces the address for the indirect phase.
        addr_q <= dmem_rdata;
      end

      if (load_en) mem_data <= load_val;

      if (state_d == IDLE)
        kill_q <= 1'b0;
      else if (((state_q == ACCESS) || (state_q == INDIRECT)) && flush)
        kill_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_access.sv
// tb_mem_access: self-checking bench for mem_access.
// A transaction-level reference model (request list per op, kill and report
// bookkeeping) is checked against the DUT on every falling edge; directed
// scenarios pin the model with hand-computed values, then a long randomized run
// with random memory wait states, stray responses, flushes and resets follows.

module tb_mem_access;

  localparam logic [2:0] OP_NONE = 3'd0;
  localparam logic [2:0] OP_LDR  = 3'd1;
  localparam logic [2:0] OP_LDB  = 3'd2;
  localparam logic [2:0] OP_STR  = 3'd3;
  localparam logic [2:0] OP_STB  = 3'd4;
  localparam logic [2:0] OP_LDI  = 3'd5;
  localparam logic [2:0] OP_STI  = 3'd6;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        valid_in = 1'b0;
  logic [2:0]  op = 3'd0;
  logic [15:0] addr_in = 16'h0;
  logic [15:0] store_data = 16'h0;
  logic        flush = 1'b0;
  logic [15:0] dmem_address;
  logic [15:0] dmem_wdata;
  logic [1:0]  dmem_byte_enable;
  logic        dmem_read;
  logic        dmem_write;
  logic        dmem_resp;
  logic [15:0] dmem_rdata;
  logic        stall;
  logic        done;
  logic [15:0] mem_data;

  mem_access dut (
    .clk              (clk),
    .reset_n          (reset_n),
    .valid_in         (valid_in),
    .op               (op),
    .addr_in          (addr_in),
    .store_data       (store_data),
    .flush            (flush),
    .dmem_address     (dmem_address),
    .dmem_wdata       (dmem_wdata),
    .dmem_byte_enable (dmem_byte_enable),
    .dmem_read        (dmem_read),
    .dmem_write       (dmem_write),
    .dmem_resp        (dmem_resp),
    .dmem_rdata       (dmem_rdata),
    .stall            (stall),
    .done             (done),
    .mem_data         (mem_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic is_memop(input logic [2:0] o);
    return (o != 3'd0) && (o != 3'd7);
  endfunction

  // ---------------- memory responder ----------------
  typedef struct packed {
    logic        wr;
    logic [15:0] a;
    logic [1:0]  be;
    logic [15:0] wd;
  } hs_t;

  hs_t         log_q[$];
  logic [15:0] rd_q[$];
  int          cfg_wait = 0;
  bit          rand_mode = 1'b0;
  bit          pending = 1'b0;
  int          wleft = 0;

  initial begin
    hs_t h;
    dmem_resp  = 1'b0;
    dmem_rdata = 16'h0;
    forever begin
      @(posedge clk); #1;
      dmem_resp  = 1'b0;
      dmem_rdata = 16'($urandom);
      if (!reset_n) begin
        pending = 1'b0;
      end else if (dmem_read || dmem_write) begin
        if (!pending) begin
          pending = 1'b1;
          wleft   = rand_mode ? int'($urandom_range(0, 3)) : cfg_wait;
        end
        if (wleft == 0) begin
          dmem_resp = 1'b1;
          pending   = 1'b0;
          if (rd_q.size() > 0) dmem_rdata = rd_q.pop_front();
          h.wr = dmem_write;
          h.a  = dmem_address;
          h.be = dmem_byte_enable;
          h.wd = dmem_wdata;
          log_q.push_back(h);
        end else begin
          wleft--;
        end
      end else begin
        pending = 1'b0;
        // Stray responses while nothing is requested must be ignored.
        if (rand_mode && ($urandom_range(0, 5) == 0)) dmem_resp = 1'b1;
      end
    end
  end

  // ---------------- reference model + compare ----------------
  // ph: 0 = nothing in flight, 1 = request outstanding, 2 = completion cycle
  int          ph = 0;
  int          idx = 0;
  bit          killed = 1'b0;
  logic [2:0]  m_op = 3'd0;
  logic [15:0] m_addr = 16'h0, m_sd = 16'h0, m_ptr = 16'h0, exp_mem = 16'h0;
  logic        e_wr;
  logic [15:0] e_a, e_wd;
  logic [1:0]  e_be;

  initial begin
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        ph      = 0;
        exp_mem = 16'h0;
        chk("rst_strobes_done", 16'({dmem_read, dmem_write, done}), 16'h0);
        chk("rst_address", dmem_address, 16'h0);
        chk("rst_wdata", dmem_wdata, 16'h0);
        chk("rst_byte_enable", 16'(dmem_byte_enable), 16'h0);
        chk("rst_mem_data", mem_data, 16'h0);
        chk("rst_stall", 16'(stall), 16'(valid_in && is_memop(op) && !flush));
      end else begin
        chk("done", 16'(done), 16'(ph == 2));
        chk("mem_data", mem_data, exp_mem);
        chk("stall", 16'(stall), 16'((ph != 0) || (valid_in && is_memop(op) && !flush)));
        if (ph == 1) begin
          if (idx == 0) begin
            e_a  = {m_addr[15:1], 1'b0};
            e_wr = (m_op == OP_STR) || (m_op == OP_STB);
            e_be = (m_op == OP_STB) ? (m_addr[0] ? 2'b10 : 2'b01) : 2'b11;
            e_wd = (m_op == OP_STB) ? {m_sd[7:0], m_sd[7:0]} : m_sd;
          end else begin
            e_a  = {m_ptr[15:1], 1'b0};
            e_wr = (m_op == OP_STI);
            e_be = 2'b11;
            e_wd = m_sd;
          end
          chk("strobes", 16'({dmem_read, dmem_write}), e_wr ? 16'h1 : 16'h2);
          chk("address", dmem_address, e_a);
          chk("byte_enable", 16'(dmem_byte_enable), 16'(e_be));
          if (e_wr) chk("wdata", dmem_wdata, e_wd);
          if (dmem_resp) begin
            if (killed || flush) begin
              ph = 0;
            end else if (((m_op == OP_LDI) || (m_op == OP_STI)) && (idx == 0)) begin
              idx   = 1;
              m_ptr = dmem_rdata;
            end else begin
              ph = 2;
              if ((m_op == OP_LDR) || (m_op == OP_LDI))
                exp_mem = dmem_rdata;
              else if (m_op == OP_LDB)
                exp_mem = m_addr[0] ? {8'h00, dmem_rdata[15:8]} : {8'h00, dmem_rdata[7:0]};
            end
          end else if (flush) begin
            killed = 1'b1;
          end
        end else begin
          chk("idle_strobes", 16'({dmem_read, dmem_write}), 16'h0);
          if (ph == 2) begin
            ph = 0;
          end else if (valid_in && is_memop(op) && !flush) begin
            ph     = 1;
            idx    = 0;
            killed = 1'b0;
            m_op   = op;
            m_addr = addr_in;
            m_sd   = store_data;
          end
        end
      end
    end
  end

  // ---------------- directed driver ----------------
  int last_brk = -1;

  task automatic run_op(input logic [2:0] o, input logic [15:0] a, input logic [15:0] sd,
                        input int flush_at, output int n_done, output int done_at);
    bit idle_seen;
    idle_seen = 1'b0;
    log_q.delete();
    n_done   = 0;
    done_at  = -1;
    last_brk = -1;
    valid_in = 1'b1; op = o; addr_in = a; store_data = sd; flush = 1'b0;
    for (int k = 1; k <= 60 && !idle_seen; k++) begin
      @(posedge clk); #1;
      valid_in = 1'b0; op = OP_NONE;
      flush = (k == flush_at);
      #1;
      if (done) begin n_done++; done_at = k; end
      if (!stall) begin idle_seen = 1'b1; last_brk = k; end
    end
    flush = 1'b0;
    chk("return_idle", 16'(idle_seen), 16'h1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nd, da;
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    #1;
    chk("reset_mem_data", mem_data, 16'h0);
    chk("reset_stall", 16'(stall), 16'h0);
    chk("reset_done", 16'(done), 16'h0);
    chk("reset_address", dmem_address, 16'h0);

    // LDR with three wait cycles
    cfg_wait = 3;
    rd_q.push_back(16'hBEEF);
    run_op(OP_LDR, 16'h3005, 16'h0, -1, nd, da);
    chk("ldr_log_size", 16'(log_q.size()), 16'd1);
    if (log_q.size() >= 1) begin
      chk("ldr_address", log_q[0].a, 16'h3004);
      chk("ldr_be", 16'(log_q[0].be), 16'h3);
      chk("ldr_is_read", 16'(log_q[0].wr), 16'h0);
    end
    chk("ldr_done_count", 16'(nd), 16'd1);
    chk("ldr_done_cycle", 16'(da), 16'd5);
    chk("ldr_stall_span", 16'(last_brk), 16'd6);
    chk("ldr_mem_data", mem_data, 16'hBEEF);

    // LDB, both byte lanes, zero wait
    cfg_wait = 0;
    rd_q.push_back(16'h12AB);
    run_op(OP_LDB, 16'h2001, 16'h0, -1, nd, da);
    chk("ldb_hi_mem_data", mem_data, 16'h0012);
    chk("ldb_hi_done_cycle", 16'(da), 16'd2);
    if (log_q.size() >= 1) chk("ldb_hi_be", 16'(log_q[0].be), 16'h3);
    rd_q.push_back(16'h12AB);
    run_op(OP_LDB, 16'h2000, 16'h0, -1, nd, da);
    chk("ldb_lo_mem_data", mem_data, 16'h00AB);

    // STB to the high byte
    run_op(OP_STB, 16'h4001, 16'h0077, -1, nd, da);
    chk("stb_log_size", 16'(log_q.size()), 16'd1);
    if (log_q.size() >= 1) begin
      chk("stb_is_write", 16'(log_q[0].wr), 16'h1);
      chk("stb_wdata", log_q[0].wd, 16'h7777);
      chk("stb_be", 16'(log_q[0].be), 16'h2);
      chk("stb_address", log_q[0].a, 16'h4000);
    end
    chk("stb_done_count", 16'(nd), 16'd1);
    chk("stb_mem_data_kept", mem_data, 16'h00AB);

    // LDI: pointer fetch then data read
    rd_q.push_back(16'h5002);
    rd_q.push_back(16'hCAFE);
    run_op(OP_LDI, 16'h1000, 16'h0, -1, nd, da);
    chk("ldi_log_size", 16'(log_q.size()), 16'd2);
    if (log_q.size() >= 2) begin
      chk("ldi_ptr_address", log_q[0].a, 16'h1000);
      chk("ldi_data_address", log_q[1].a, 16'h5002);
      chk("ldi_data_is_read", 16'(log_q[1].wr), 16'h0);
    end
    chk("ldi_mem_data", mem_data, 16'hCAFE);
    chk("ldi_done_count", 16'(nd), 16'd1);
    chk("ldi_done_cycle", 16'(da), 16'd3);

    // STI flushed during the pointer fetch
    cfg_wait = 2;
    rd_q.push_back(16'h6000);
    run_op(OP_STI, 16'h1234, 16'h5555, 1, nd, da);
    chk("sti_flush_log_size", 16'(log_q.size()), 16'd1);
    if (log_q.size() >= 1) chk("sti_flush_fetch_read", 16'(log_q[0].wr), 16'h0);
    chk("sti_flush_done_count", 16'(nd), 16'd0);
    chk("sti_flush_mem_data", mem_data, 16'hCAFE);

    // flush during the completion cycle does not cancel it
    cfg_wait = 0;
    rd_q.push_back(16'h1357);
    run_op(OP_LDR, 16'h0100, 16'h0, 2, nd, da);
    chk("report_flush_done_count", 16'(nd), 16'd1);
    chk("report_flush_mem_data", mem_data, 16'h1357);

    // flush wins over valid_in in IDLE
    valid_in = 1'b1; op = OP_LDR; addr_in = 16'h0200; flush = 1'b1;
    #1 chk("idle_flush_stall", 16'(stall), 16'h0);
    @(posedge clk); #1;
    valid_in = 1'b0; op = OP_NONE; flush = 1'b0;
    #1 chk("idle_flush_no_access", 16'({dmem_read, dmem_write}), 16'h0);

    // reset in the middle of a pending LDR
    cfg_wait = 10;
    @(posedge clk); #1;
    valid_in = 1'b1; op = OP_LDR; addr_in = 16'h3000;
    @(posedge clk); #1;
    valid_in = 1'b0; op = OP_NONE;
    @(posedge clk); #1;
    #1 chk("pending_read", 16'(dmem_read), 16'h1);
    reset_n = 1'b0;
    #1;
    chk("mid_rst_strobes", 16'({dmem_read, dmem_write, done, stall}), 16'h0);
    chk("mid_rst_address", dmem_address, 16'h0);
    chk("mid_rst_mem_data", mem_data, 16'h0);
    chk("mid_rst_be", 16'(dmem_byte_enable), 16'h0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    valid_in = 1'b1; op = OP_NONE;
    #1 chk("none_op_stall", 16'(stall), 16'h0);
    repeat (3) begin
      @(posedge clk); #2;
      chk("none_op_no_access", 16'({dmem_read, dmem_write, done}), 16'h0);
    end
    valid_in = 1'b0;

    // randomized traffic
    rand_mode = 1'b1;
    repeat (4000) begin
      @(posedge clk); #1;
      reset_n    = ($urandom_range(0, 299) != 0);
      valid_in   = ($urandom_range(0, 3) != 0);
      op         = 3'($urandom);
      addr_in    = 16'($urandom);
      store_data = 16'($urandom);
      flush      = ($urandom_range(0, 9) == 0);
    end
    @(posedge clk); #1;
    reset_n = 1'b1; valid_in = 1'b0; flush = 1'b0; rand_mode = 1'b0;
    cfg_wait = 0;
    repeat (20) @(posedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
MEM_ACCESS -- requirements
Module: mem_access

Interface
REQ-001 No parameters; all data paths SHALL be 16 bits (lc3b_word).
REQ-002 clk  in  1  rising-edge clock for all state.
REQ-003 reset_n  in  1  asynchronous, active-low reset.
REQ-004 valid_in  in  1  EX/MEM register holds an instruction for this stage this cycle.
REQ-005 op  in  3  000 none, 001 LDR, 010 LDB, 011 STR, 100 STB, 101 LDI, 110 STI, 111 treated as none.
REQ-006 addr_in  in  16  effective address from the EX-stage ALU.
REQ-007 store_data  in  16  source register data for stores.
REQ-008 flush  in  1  kill the current/pending access result.
REQ-009 dmem_address  out  16  data-memory address.
REQ-010 dmem_wdata  out  16  data-memory write data.
REQ-011 dmem_byte_enable  out  2  byte lanes: [1] high byte, [0] low byte.
REQ-012 dmem_read / dmem_write  out  1 each  request strobes, never both high.
REQ-013 dmem_resp  in  1  one-cycle completion of the current request.
REQ-014 dmem_rdata  in  16  read data, valid with dmem_resp.
REQ-015 stall  out  1  upstream SHALL NOT advance while high.
REQ-016 done  out  1  one-cycle pulse: access complete, mem_data valid.
REQ-017 mem_data  out  16  load result, held until the next done.

Function
REQ-018 FSM states SHALL be IDLE, ACCESS, INDIRECT, and REPORT.
REQ-019 IDLE, with valid_in=1, op a memory op, and flush=0: latch op/addr_in/store_data, go to ACCESS; op none: stay IDLE, no done.
REQ-020 ACCESS SHALL assert dmem_read (loads, LDI/STI pointer fetch) or dmem_write (STR/STB) from the first ACCESS cycle, holding address/wdata/strobe stable until dmem_resp.
REQ-021 On dmem_resp in ACCESS: LDI/STI SHALL latch dmem_rdata as the new address and go to INDIRECT; all others SHALL go to REPORT.
REQ-022 INDIRECT SHALL issue a word read (LDI) or word write of latched store_data (STI) at the latched pointer, going to REPORT on dmem_resp.
REQ-023 REPORT SHALL last exactly one cycle with done=1, then return to IDLE; mem_data SHALL update on the same edge that enters REPORT.
REQ-024 Word accesses SHALL drive dmem_address = {addr[15:1],0} and byte_enable = 11.
REQ-025 LDB SHALL read with byte_enable 11, and mem_data = {8'h00, selected byte}, high byte if addr[0]=1.
REQ-026 STB SHALL drive wdata = {store_data[7:0], store_data[7:0]} and byte_enable = 10 if addr[0]=1, else 01.
REQ-027 Stores SHALL leave mem_data unchanged.
REQ-028 stall SHALL equal (state != IDLE) OR (state == IDLE AND valid_in AND memory op AND NOT flush).
REQ-029 Minimum latency: single access with resp in the first ACCESS cycle gives done 2 cycles after acceptance; LDI/STI gives done after 2 responses plus 1 cycle.
REQ-030 A wait of any length in ACCESS/INDIRECT SHALL be tolerated with no timeout.
REQ-031 flush in IDLE SHALL block acceptance, with flush winning over a simultaneous valid_in.
REQ-032 flush in ACCESS/INDIRECT SHALL set a kill flag; the outstanding request SHALL complete its handshake, no further indirect phase issues, and the FSM returns to IDLE with no done and mem_data unchanged.
REQ-033 flush in REPORT SHALL NOT cancel the done already reported.
REQ-034 dmem_resp outside ACCESS/INDIRECT SHALL be ignored.

Reset
REQ-035 reset_n=0 SHALL immediately force IDLE; clear the kill flag; drive dmem_read, dmem_write, done, and stall (valid_in low) to 0; and set dmem_address, dmem_wdata, dmem_byte_enable, and mem_data to 0.
REQ-036 Reset mid-access SHALL abandon the request with no done; the memory model is reset alongside.

Verification
REQ-037 LDR addr_in=0x3005, rdata=0xBEEF, resp after 3 wait cycles -> dmem_address=0x3004, be=11, stall high throughout, done one cycle after resp, mem_data=0xBEEF.
REQ-038 LDB addr 0x2001, rdata 0x12AB -> mem_data=0x0012; at addr 0x2000 -> mem_data=0x00AB.
REQ-039 STB addr 0x4001, store_data 0x0077 -> dmem_write, wdata=0x7777, be=10, mem_data unchanged, done pulses.
REQ-040 LDI addr 0x1000, first rdata 0x5002, second rdata 0xCAFE -> second read at 0x5002, mem_data=0xCAFE, exactly one done.
REQ-041 STI with flush asserted during pointer fetch -> fetch completes, no write issued, no done, FSM returns to IDLE.
REQ-042 reset_n low during a pending LDR -> all outputs 0 at once; after release, valid_in with op=000 -> no access, stall=0.
